// File: rtl/camera_config_sequencer.sv
// Walks the OV7670 configuration ROM and turns each {reg, data} entry into an SCCB
// write. 16'hFFF0 inserts a settle delay, 16'hFFFF ends the run, other 16'hFFxx entries
// are skipped. Stops at address 255 if no terminator is found.
module camera_config_sequencer #(
  parameter int unsigned DELAY_CYCLES = 1_000_000,
  parameter int unsigned DELAY_W      = $clog2(DELAY_CYCLES + 1)
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_start,
  output logic [7:0]  o_rom_addr,
  input  logic [15:0] i_rom_data,
  output logic        o_sccb_valid,
  output logic [7:0]  o_sccb_reg,
  output logic [7:0]  o_sccb_data,
  input  logic        i_sccb_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic [7:0]  o_write_count
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWaitRom,
    StDecode,
    StWrite,
    StDelay,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [7:0]         addr_q, addr_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  logic [7:0]         reg_q, reg_d;
  logic [7:0]         data_q, data_d;
  logic [7:0]         count_q, count_d;

  // Set when the current entry is finished and the walk moves to the next one.
  logic advance;
  logic accept;
  logic start_ok;
  logic is_term, is_delay, is_skip;

  assign accept   = (state_q == StWrite) && i_sccb_ready;
  assign start_ok = ((state_q == StIdle) || (state_q == StDone)) && i_start;
  assign is_term  = (i_rom_data == 16'hFFFF);
  assign is_delay = (i_rom_data == 16'hFFF0);
  assign is_skip  = (i_rom_data[15:8] == 8'hFF) && !is_term && !is_delay;

  // State register; reset abandons any run in progress.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (i_start) state_d = StFetch;
      end
      StFetch:   state_d = StWaitRom;
      StWaitRom: state_d = StDecode;
      StDecode: begin
        if (is_term) begin
          state_d = StDone;
        end else if (is_delay) begin
          state_d = StDelay;
        end else if (is_skip) begin
          advance = 1'b1;
        end else begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (i_sccb_ready) advance = 1'b1;
      end
      StDelay: begin
        if (cnt_q == '0) advance = 1'b1;
      end
      default: state_d = StIdle;
    endcase
    // Address 255 is the last entry; no wrap, so a missing terminator still ends the run.
    if (advance) state_d = (addr_q == 8'hFF) ? StDone : StFetch;
  end

  // Datapath registers: address, delay counter, latched write and write counter.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      addr_q  <= '0;
      cnt_q   <= '0;
      reg_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  // Datapath next-state.
  always_comb begin
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    reg_d   = reg_q;
    data_d  = data_q;
    count_d = count_q;
    if (start_ok) begin
      addr_d  = '0;
      count_d = '0;
    end
    if ((state_q == StDecode) && is_delay) begin
      cnt_d = DELAY_W'(DELAY_CYCLES - 1);
    end
    if ((state_q == StDelay) && (cnt_q != '0)) begin
      cnt_d = cnt_q - DELAY_W'(1);
    end
    // Only real writes update the SCCB payload; it then holds until accepted.
    if ((state_q == StDecode) && (i_rom_data[15:8] != 8'hFF)) begin
      reg_d  = i_rom_data[15:8];
      data_d = i_rom_data[7:0];
    end
    if (accept && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
    if (advance && (addr_q != 8'hFF)) begin
      addr_d = addr_q + 8'd1;
    end
  end

  // Outputs: valid comes from the registered state, so ready has no path to it.
  always_comb begin
    o_rom_addr    = addr_q;
    o_sccb_valid  = (state_q == StWrite);
    o_sccb_reg    = reg_q;
    o_sccb_data   = data_q;
    o_busy        = (state_q != StIdle) && (state_q != StDone);
    o_done        = (state_q == StDone);
    o_write_count = count_q;
  end

endmodule

// File: tb/tb_camera_config_sequencer.sv
// Bench for camera_config_sequencer: registered ROM model, randomized ROM contents and
// SCCB backpressure, checked against an entry-level reference model.
module tb_camera_config_sequencer;

  localparam int unsigned D = 12;

  logic        clk = 1'b0;
  logic        rstn, start, ready;
  logic [7:0]  rom_addr, sreg, sdata, wcount;
  logic [15:0] rom_data = '0;
  logic        valid, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] rom [256];
  logic [15:0] got_q[$];
  int          got_cyc[$];
  int          cyc = 0;

  logic [15:0] exp_q[$];
  int          exp_cycles;
  logic [7:0]  exp_addr;
  int          busy_cycles;
  bit          timed_out;
  logic        done_after_start;

  camera_config_sequencer #(.DELAY_CYCLES(D)) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_start      (start),
    .o_rom_addr   (rom_addr),
    .i_rom_data   (rom_data),
    .o_sccb_valid (valid),
    .o_sccb_reg   (sreg),
    .o_sccb_data  (sdata),
    .i_sccb_ready (ready),
    .o_busy       (busy),
    .o_done       (done),
    .o_write_count(wcount)
  );

  always #5 clk = ~clk;

  // ROM with one registered read stage.
  always @(posedge clk) rom_data <= rom[rom_addr];
  always @(posedge clk) cyc <= cyc + 1;

  // Log every accepted write with its cycle number.
  always @(negedge clk) begin
    if (valid && ready) begin
      got_q.push_back({sreg, sdata});
      got_cyc.push_back(cyc);
    end
  end

  function automatic logic [15:0] rand_write();
    logic [15:0] e;
    e[15:8] = 8'($urandom_range(0, 254));
    e[7:0]  = 8'($urandom);
    return e;
  endfunction

  task automatic fill_rom(input logic [15:0] v);
    for (int a = 0; a < 256; a++) rom[a] = v;
  endtask

  // Reference: walk entries, collect writes and busy-cycle cost with ready held high.
  task automatic build_model();
    logic [15:0] e;
    exp_q.delete();
    exp_cycles = 0;
    exp_addr   = '0;
    for (int a = 0; a < 256; a++) begin
      e = rom[a];
      exp_addr = 8'(a);
      if (e == 16'hFFFF) begin
        exp_cycles += 3;
        break;
      end else if (e == 16'hFFF0) begin
        exp_cycles += 3 + int'(D);
      end else if (e[15:8] == 8'hFF) begin
        exp_cycles += 3;
      end else begin
        exp_q.push_back(e);
        exp_cycles += 4;
      end
    end
  endtask

  function automatic logic [7:0] exp_count();
    return (exp_q.size() > 255) ? 8'd255 : 8'(exp_q.size());
  endfunction

  task automatic run_seq(input bit rand_ready, input bit poke_start, input int max_cycles);
    got_q.delete();
    got_cyc.delete();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    done_after_start = done;
    busy_cycles = 0;
    timed_out = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      if (busy) busy_cycles++;
      @(posedge clk); #1;
      ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke_start) start = ($urandom_range(0, 3) == 0);
    end
    start = 1'b0;
    ready = 1'b1;
    n_cmp++;
    if (timed_out) begin
      n_err++;
      $display("FAIL run_timeout: done=0 after %0d cycles, required done=1", max_cycles);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; ready = 1'b1;
    #3;
    n_cmp++;
    if ({rom_addr, valid, sreg, sdata, busy, done, wcount} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h, required 0",
               {rom_addr, valid, sreg, sdata, busy, done, wcount});
    end
    #20 rstn = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, valid} !== 3'b000) begin
      n_err++;
      $display("FAIL idle_hold: busy/done/valid=%b, required 000", {busy, done, valid});
    end
  endtask

  task automatic test_main_sequence();
    fill_rom(16'hFFFF);
    rom[0] = 16'h1280;
    rom[1] = 16'hFFF0;
    rom[2] = 16'h1214;
    for (int a = 3; a < 76; a++) rom[a] = rand_write();
    rom[76] = 16'h6906;
    build_model();
    run_seq(1'b0, 1'b0, 3000);
    n_cmp++;
    if (got_q.size() != 76) begin
      n_err++; $display("FAIL main_nwrites: got %0d, required 76", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL main_write[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    if (got_q.size() == 76) begin
      n_cmp++;
      if ({got_q[0], got_q[1], got_q[75]} !== {16'h1280, 16'h1214, 16'h6906}) begin
        n_err++; $display("FAIL main_first_second_last: got %h %h %h, required 1280 1214 6906",
                          got_q[0], got_q[1], got_q[75]);
      end
      // Write 0 cycle -> FETCH/WAIT/DECODE of FFF0, D delay cycles, FETCH/WAIT/DECODE, WRITE.
      n_cmp++;
      if (got_cyc[1] - got_cyc[0] != int'(D) + 7) begin
        n_err++; $display("FAIL main_delay_gap: got %0d, required %0d",
                          got_cyc[1] - got_cyc[0], int'(D) + 7);
      end
    end
    n_cmp++;
    if ({done, busy, wcount} !== {1'b1, 1'b0, 8'd76}) begin
      n_err++; $display("FAIL main_done_count: done=%b busy=%b count=%0d, required 1 0 76",
                        done, busy, wcount);
    end
    n_cmp++;
    if (busy_cycles != exp_cycles) begin
      n_err++; $display("FAIL main_busy_cycles: got %0d, required %0d", busy_cycles, exp_cycles);
    end
  endtask

  task automatic test_backpressure();
    int held;
    int bad;
    bit fin;
    fill_rom(16'hFFFF);
    for (int a = 0; a < 3; a++) rom[a] = rand_write();
    rom[3] = 16'h1100;
    rom[4] = rand_write();
    got_q.delete();
    held = 0; bad = 0; fin = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin
        fin = 1'b1;
        break;
      end
      if (valid && !ready) begin
        held++;
        if ({valid, sreg, sdata} !== {1'b1, 8'h11, 8'h00} || wcount !== 8'd3) bad++;
      end
      @(posedge clk); #1;
      ready = !((rom_addr == 8'd3) && (held < 7));
    end
    ready = 1'b1;
    n_cmp++;
    if (!fin) begin
      n_err++; $display("FAIL bp_timeout: done=0, required done=1");
    end
    n_cmp++;
    if (held != 7 || bad != 0) begin
      n_err++; $display("FAIL bp_hold: stalled %0d cycles (%0d unstable), required 7 (0)",
                        held, bad);
    end
    n_cmp++;
    if (got_q.size() != 5 || got_q[3] !== 16'h1100 || wcount !== 8'd5) begin
      n_err++; $display("FAIL bp_count: writes=%0d count=%0d, required 5 5", got_q.size(), wcount);
    end
  endtask

  task automatic test_no_terminator();
    int bad;
    fill_rom(16'h0155);
    build_model();
    run_seq(1'b0, 1'b0, 3000);
    bad = 0;
    foreach (got_q[i]) if (got_q[i] !== 16'h0155) bad++;
    n_cmp++;
    if (got_q.size() != 256 || bad != 0) begin
      n_err++; $display("FAIL noterm_writes: got %0d (%0d wrong), required 256", got_q.size(), bad);
    end
    n_cmp++;
    if ({done, rom_addr, wcount} !== {1'b1, 8'd255, 8'd255}) begin
      n_err++; $display("FAIL noterm_final: done=%b addr=%0d count=%0d, required 1 255 255",
                        done, rom_addr, wcount);
    end
    n_cmp++;
    if (busy_cycles != exp_cycles) begin
      n_err++; $display("FAIL noterm_cycles: got %0d, required %0d", busy_cycles, exp_cycles);
    end
  endtask

  task automatic test_skip();
    fill_rom(16'hFFFF);
    for (int a = 0; a < 6; a++) rom[a] = rand_write();
    rom[2] = 16'hFF3C;
    build_model();
    run_seq(1'b0, 1'b0, 500);
    n_cmp++;
    if (wcount !== 8'd5 || got_q.size() != 5) begin
      n_err++; $display("FAIL skip_count: count=%0d writes=%0d, required 5", wcount, got_q.size());
    end
    n_cmp++;
    if (got_q.size() >= 3 && got_q[2] !== rom[3]) begin
      n_err++; $display("FAIL skip_next: got %h, required %h", got_q[2], rom[3]);
    end
    n_cmp++;
    if (busy_cycles != exp_cycles) begin
      n_err++; $display("FAIL skip_cycles: got %0d, required %0d", busy_cycles, exp_cycles);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    fill_rom(16'hFFFF);
    rom[0] = rand_write();
    rom[1] = 16'hFFF0;
    rom[2] = rand_write();
    got_q.delete();
    // Reset inside the delay.
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = (got_q.size() == 1);
    end
    repeat (6) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    n_cmp++;
    if (!seen || {rom_addr, valid, sreg, sdata, busy, done, wcount} !== 35'd0) begin
      n_err++; $display("FAIL rst_delay: seen=%b outputs=%h, required 1 and 0", seen,
                        {rom_addr, valid, sreg, sdata, busy, done, wcount});
    end
    #10 rstn = 1'b1;
    // Reset while a write is pending.
    ready = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = valid;
    end
    #2 rstn = 1'b0;
    #1;
    n_cmp++;
    if (!seen || {rom_addr, valid, sreg, sdata, busy, done, wcount} !== 35'd0) begin
      n_err++; $display("FAIL rst_write: seen=%b outputs=%h, required 1 and 0", seen,
                        {rom_addr, valid, sreg, sdata, busy, done, wcount});
    end
    #10 rstn = 1'b1;
    ready = 1'b1;
    // Fresh run from address 0.
    build_model();
    run_seq(1'b0, 1'b0, 500);
    n_cmp++;
    if (got_q.size() != 2 || got_q[0] !== rom[0] || got_q[1] !== rom[2] || wcount !== 8'd2) begin
      n_err++; $display("FAIL rst_restart: writes=%0d first=%h count=%0d, required 2 %h 2",
                        got_q.size(), got_q[0], wcount, rom[0]);
    end
  endtask

  task automatic test_start_ignored_and_rerun();
    logic [15:0] first_q[$];
    int bad;
    fill_rom(16'hFFFF);
    for (int a = 0; a < 20; a++) rom[a] = rand_write();
    rom[5]  = 16'hFF12;
    rom[9]  = 16'hFFF0;
    build_model();
    run_seq(1'b0, 1'b1, 1000);
    bad = 0;
    foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
    n_cmp++;
    if (bad != 0 || got_q.size() != exp_q.size() || busy_cycles != exp_cycles) begin
      n_err++; $display("FAIL start_ignored: writes=%0d bad=%0d cycles=%0d, required %0d 0 %0d",
                        got_q.size(), bad, busy_cycles, exp_q.size(), exp_cycles);
    end
    first_q = got_q;
    run_seq(1'b0, 1'b0, 1000);
    n_cmp++;
    if (done_after_start !== 1'b0) begin
      n_err++; $display("FAIL rerun_done_clear: got %b, required 0", done_after_start);
    end
    bad = 0;
    foreach (first_q[i]) if (i >= got_q.size() || got_q[i] !== first_q[i]) bad++;
    n_cmp++;
    if (bad != 0 || got_q.size() != first_q.size() || wcount !== exp_count()) begin
      n_err++; $display("FAIL rerun_same: writes=%0d bad=%0d count=%0d, required %0d 0 %0d",
                        got_q.size(), bad, wcount, first_q.size(), exp_count());
    end
  endtask

  task automatic test_random();
    int len;
    int bad;
    int r;
    for (int it = 0; it < 4; it++) begin
      fill_rom(16'hFFFF);
      len = $urandom_range(5, 40);
      for (int a = 0; a < len; a++) begin
        r = $urandom_range(0, 9);
        if (r == 0)      rom[a] = 16'hFFF0;
        else if (r == 1) rom[a] = {8'hFF, 8'($urandom_range(0, 8'hEF))};
        else             rom[a] = rand_write();
      end
      build_model();
      run_seq(1'b1, 1'b0, 3000);
      bad = 0;
      foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
      n_cmp++;
      if (bad != 0 || got_q.size() != exp_q.size()) begin
        n_err++; $display("FAIL random%0d_writes: got %0d (%0d wrong), required %0d",
                          it, got_q.size(), bad, exp_q.size());
      end
      n_cmp++;
      if ({done, wcount, rom_addr} !== {1'b1, exp_count(), exp_addr}) begin
        n_err++; $display("FAIL random%0d_final: done=%b count=%0d addr=%0d, required 1 %0d %0d",
                          it, done, wcount, rom_addr, exp_count(), exp_addr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_main_sequence();
    test_backpressure();
    test_no_terminator();
    test_skip();
    test_reset_mid();
    test_start_ignored_and_rerun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
